// File: rtl/dsp_divider_sequential_pkg.sv
// Shared definitions for the sequential divide/subtract block:
// FSM state encoding, operation mode encoding and default width.
package dsp_divider_sequential_pkg;

    localparam int DATA_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_SUB = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

endpackage

// File: rtl/dsp_divider_sequential_if.sv
// Operand/result handshake bundle for the sequential divider.
// master = producer of operands and consumer of results; slave = the divider.
interface dsp_divider_sequential_if
    import dsp_divider_sequential_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     a;
    logic [DATA_WIDTH/2-1:0]   b;
    logic                      m;
    logic [DATA_WIDTH-1:0]     q;
    logic [DATA_WIDTH/2-1:0]   r;
    logic                      flag;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_valid, a, b, m, out_ready,
        input  in_ready, q, r, flag, out_valid
    );

    modport slave (
        input  in_valid, a, b, m, out_ready,
        output in_ready, q, r, flag, out_valid
    );
endinterface

// File: rtl/dsp_divider_sequential_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, try to subtract the divisor, keep the difference only
// when it did not go negative.
module dsp_div_step #(
    parameter int HW = 2
) (
    input  logic [HW-1:0] rem_in,
    input  logic          dbit,
    input  logic [HW-1:0] divisor,
    output logic [HW-1:0] rem_out,
    output logic          qbit
);
    logic [HW:0] shifted;
    logic [HW:0] diff;
    logic        unused_diff_msb;

    // Remainder is always < divisor, so the shifted value fits in HW+1 bits
    // and the accepted difference fits back in HW bits.
    always_comb begin
        shifted = {rem_in, dbit};
        diff    = shifted - {1'b0, divisor};
        qbit    = (shifted >= {1'b0, divisor});
        rem_out = qbit ? diff[HW-1:0] : shifted[HW-1:0];
    end

    assign unused_diff_msb = diff[HW];

endmodule

// File: rtl/dsp_divider_sequential.sv
// Sequential divide / subtract unit. Divide runs restoring division, one
// quotient bit per cycle MSB first; subtract and divide-by-zero finish at accept.
module dsp_divider_sequential
    import dsp_divider_sequential_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    dsp_divider_sequential_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int HW = DATA_WIDTH / 2;
    localparam int CW = $clog2(DATA_WIDTH);

    state_t          state, state_nxt;
    logic [W-1:0]    dvd_sh;     // dividend shifts out MSB first, quotient shifts in
    logic [HW-1:0]   dvs;
    logic [HW-1:0]   rem;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    q_reg;
    logic [HW-1:0]   r_reg;
    logic            flag_reg;
    logic [HW-1:0]   step_rem;
    logic            step_q;
    logic            accept;
    logic            is_div;

    assign accept = (state == ST_IDLE) && bus.in_valid;
    assign is_div = (mode_t'(bus.m) == MODE_DIV);

    dsp_div_step #(.HW(HW)) u_step (
        .rem_in  (rem),
        .dbit    (dvd_sh[W-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .qbit    (step_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; only BUSY for a real division.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid) state_nxt = (is_div && bus.b != '0) ? ST_BUSY : ST_DONE;
            ST_BUSY: if (cnt == '0)    state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, division iterations and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_sh   <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
            flag_reg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dvd_sh <= bus.a;
                        dvs    <= bus.b;
                        rem    <= '0;
                        cnt    <= CW'(W - 1);
                        if (!is_div) begin
                            q_reg    <= bus.a - {{(W-HW){1'b0}}, bus.b};
                            r_reg    <= '0;
                            flag_reg <= (bus.a < {{(W-HW){1'b0}}, bus.b});
                        end else if (bus.b == '0) begin
                            q_reg    <= '1;
                            r_reg    <= '0;
                            flag_reg <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    rem    <= step_rem;
                    dvd_sh <= {dvd_sh[W-2:0], step_q};
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        q_reg    <= {dvd_sh[W-2:0], step_q};
                        r_reg    <= step_rem;
                        flag_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags decode straight from the state register.
    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_DONE);
        bus.q         = q_reg;
        bus.r         = r_reg;
        bus.flag      = flag_reg;
    end

endmodule

// File: tb/tb_dsp_divider_sequential.sv
// Randomized bench for dsp_divider_sequential against an arithmetic reference.
module tb_dsp_divider_sequential;
    localparam int W  = 4;
    localparam int HW = W / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dsp_divider_sequential_if #(.DATA_WIDTH(W)) bus ();

    dsp_divider_sequential #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_q"},         32'(bus.q),         32'd0);
        chk({tag, "_r"},         32'(bus.r),         32'd0);
        chk({tag, "_flag"},      32'(bus.flag),      32'd0);
    endtask

    // Offer one operand set, wait for the result, optionally stall, consume it.
    task automatic do_op(input int a, input int b, input bit m, input int stall, input bit consume);
        int eq, er, ef, elat, lat, g;
        logic [W-1:0] hq;
        logic [HW-1:0] hr;
        logic hf;
        if (m) begin
            if (b == 0) begin eq = (1 << W) - 1; er = 0; ef = 1; end
            else        begin eq = a / b;        er = a % b; ef = 0; end
            elat = (b == 0) ? 1 : W + 1;
        end else begin
            eq = (a - b) & ((1 << W) - 1); er = 0; ef = (a < b) ? 1 : 0; elat = 1;
        end
        g = 0;
        while (!bus.in_ready && g < 50) begin @(negedge clk); g++; end
        chk("in_ready_pre", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a = W'(a);
        bus.b = HW'(b);
        bus.m = m;
        @(negedge clk);
        // Operands must have been captured at the accept edge; scramble them.
        bus.in_valid = 1'b0;
        bus.a = W'($urandom);
        bus.b = HW'($urandom);
        bus.m = 1'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            chk("in_ready_wait", 32'(bus.in_ready), 32'd0);
            bus.in_valid = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("out_valid", 32'(bus.out_valid), 32'd1);
        chk("latency", 32'(lat), 32'(elat));
        chk("q", 32'(bus.q), 32'(eq));
        chk("r", 32'(bus.r), 32'(er));
        chk("flag", 32'(bus.flag), 32'(ef));
        hq = bus.q; hr = bus.r; hf = bus.flag;
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'($urandom);
            bus.a = W'($urandom);
            bus.b = HW'($urandom);
            bus.m = 1'($urandom);
            @(negedge clk);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_q", 32'({bus.q, bus.r, bus.flag}), 32'({hq, hr, hf}));
        end
        bus.in_valid = 1'b0;
        if (consume) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk("post_out_valid", 32'(bus.out_valid), 32'd0);
            chk("post_in_ready", 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.m         = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        do_op(13, 3, 1'b1, 0, 1'b1);
        do_op(15, 1, 1'b1, 0, 1'b1);
        do_op(2,  3, 1'b1, 0, 1'b1);
        do_op(9,  0, 1'b1, 0, 1'b1);
        do_op(2,  3, 1'b0, 0, 1'b1);
        do_op(7,  3, 1'b0, 0, 1'b1);
        do_op(0,  0, 1'b0, 0, 1'b1);
        do_op(14, 2, 1'b1, 3, 1'b1);

        // Reset on the second BUSY cycle aborts the division.
        bus.in_valid = 1'b1; bus.a = 4'd13; bus.b = 2'd3; bus.m = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_reset("abort");
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_stale", 32'(bus.out_valid), 32'd0);
        end
        bus.out_ready = 1'b0;
        do_op(6, 2, 1'b1, 0, 1'b1);

        // Reset from DONE with reset and out_ready together.
        do_op(11, 2, 1'b1, 1, 1'b0);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk_idle_reset("done_rst");

        // Randomized operations with random backpressure.
        for (int n = 0; n < 150; n++)
            do_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << HW) - 1)),
                  1'($urandom), int'($urandom_range(0, 3)), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
